// File: rtl/ife_block_builder_if.sv
// ife_block_builder_if: bundle between the instruction source, the block
// builder and the dispatch unit.
//   instr_in/instr_valid/instr_ready : serial instruction stream
//   flush                            : close the current partial block
//   block_data_out/block_id_out/
//   block_len_out/block_valid_out    : head block of the builder FIFO
//   block_accept                     : dispatch consumed the head block
//   fifo_count                       : number of buffered blocks
// master = stream source / dispatch side, slave = builder.
interface ife_block_builder_if #(
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LEN_W = $clog2(BLOCK_SIZE + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]                  instr_in;
  logic                         instr_valid;
  logic                         instr_ready;
  logic                         flush;
  logic [BLOCK_SIZE-1:0][31:0]  block_data_out;
  logic [7:0]                   block_id_out;
  logic [LEN_W-1:0]             block_len_out;
  logic                         block_valid_out;
  logic                         block_accept;
  logic [CNT_W-1:0]             fifo_count;

  modport master (
    output instr_in, instr_valid, flush, block_accept,
    input  instr_ready, block_data_out, block_id_out, block_len_out,
           block_valid_out, fifo_count
  );

  modport slave (
    input  instr_in, instr_valid, flush, block_accept,
    output instr_ready, block_data_out, block_id_out, block_len_out,
           block_valid_out, fifo_count
  );
endinterface

// File: rtl/ife_block_builder.sv
// ife_block_builder: packs a serial 32-bit instruction stream into blocks of
// BLOCK_SIZE words, tags each with an 8-bit sequential ID and buffers
// completed blocks in a FIFO_DEPTH-entry block FIFO. A flush closes a
// partial block, padding unused slots with NOP_WORD.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : ife_block_builder_if slave (stream in, block FIFO head out)
module ife_block_builder #(
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  ife_block_builder_if.slave   bus
);
  localparam int unsigned LEN_W = $clog2(BLOCK_SIZE + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {FILL, FLUSH_WAIT} state_t;

  state_t                      state_q, state_d;
  logic [BLOCK_SIZE-1:0][31:0] slot_q, slot_d;
  logic [LEN_W-1:0]            fill_q, fill_d;
  logic [7:0]                  next_id_q;

  logic [BLOCK_SIZE-1:0][31:0] fifo_data [FIFO_DEPTH];
  logic [7:0]                  fifo_id   [FIFO_DEPTH];
  logic [LEN_W-1:0]            fifo_len  [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q;

  logic                        fifo_full, fifo_empty;
  logic                        xfer, push, pop;
  logic [LEN_W-1:0]            eff_count;
  logic [BLOCK_SIZE-1:0][31:0] push_data;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && bus.block_accept;

  // State register and builder-side datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      fill_q    <= '0;
      slot_q    <= '0;
      next_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      slot_q  <= slot_d;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        next_id_q <= next_id_q + 8'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Block storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_data[wr_ptr_q] <= push_data;
      fifo_id[wr_ptr_q]   <= next_id_q;
      fifo_len[wr_ptr_q]  <= eff_count;
    end
  end

  // Next-state logic. The block being pushed is assembled from slot_d so a
  // word arriving on the closing edge lands in the pushed block.
  always_comb begin
    xfer      = bus.instr_valid && bus.instr_ready;
    eff_count = fill_q + LEN_W'(xfer);
    slot_d    = slot_q;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      if (xfer && (LEN_W'(i) == fill_q)) slot_d[i] = bus.instr_in;
    end
    state_d = state_q;
    fill_d  = fill_q;
    push    = 1'b0;
    unique case (state_q)
      FILL: begin
        // A full block can only complete while the FIFO has room, since
        // instr_ready is held low when full with one slot left.
        if (eff_count == LEN_W'(BLOCK_SIZE)) begin
          push   = 1'b1;
          fill_d = '0;
        end else if (bus.flush && (eff_count != '0)) begin
          if (fifo_full) begin
            state_d = FLUSH_WAIT;
            fill_d  = eff_count;
          end else begin
            push   = 1'b1;
            fill_d = '0;
          end
        end else begin
          fill_d = eff_count;
        end
      end
      FLUSH_WAIT: begin
        if (!fifo_full) begin
          push    = 1'b1;
          fill_d  = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      push_data[i] = (LEN_W'(i) < eff_count) ? slot_d[i] : NOP_WORD;
    end
  end

  // Outputs
  always_comb begin
    bus.instr_ready = 1'b0;
    if (!rst && (state_q == FILL)) begin
      bus.instr_ready = !(fifo_full && (fill_q == LEN_W'(BLOCK_SIZE - 1)));
    end
    bus.block_valid_out = !fifo_empty;
    bus.fifo_count      = count_q;
    bus.block_data_out  = '0;
    bus.block_id_out    = '0;
    bus.block_len_out   = '0;
    if (!fifo_empty) begin
      bus.block_data_out = fifo_data[rd_ptr_q];
      bus.block_id_out   = fifo_id[rd_ptr_q];
      bus.block_len_out  = fifo_len[rd_ptr_q];
    end
  end
endmodule

// File: tb/tb_ife_block_builder.sv
module tb_ife_block_builder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [3:0][31:0] exp_data;

  always #5 clk = ~clk;

  ife_block_builder_if #(.BLOCK_SIZE(4), .FIFO_DEPTH(4)) bus ();

  ife_block_builder #(.BLOCK_SIZE(4), .FIFO_DEPTH(4), .NOP_WORD(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stream n consecutive words starting at base; returns at the negedge
  // after the last transfer edge with instr_valid dropped.
  task automatic send_words(input logic [31:0] base, input int n, output bit ok);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < n + 40) begin
      @(negedge clk);
      bus.instr_in    = base + 32'(sent);
      bus.instr_valid = 1'b1;
      #1;
      if (bus.instr_ready) sent++;
      guard++;
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    ok = (sent == n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.flush = 1'b0; bus.block_accept = 1'b0; bus.instr_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.flush = 1'b0; bus.block_accept = 1'b0; bus.instr_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.block_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.block_valid_out); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    checks++; if (bus.block_id_out !== 8'd0) begin errors++; $display("FAIL reset_id got %0d want 0", bus.block_id_out); end
    checks++; if (bus.block_len_out !== 3'd0) begin errors++; $display("FAIL reset_len got %0d want 0", bus.block_len_out); end
    checks++; if (bus.block_data_out !== 128'd0) begin errors++; $display("FAIL reset_data got %0h want 0", bus.block_data_out); end
    checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.instr_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %0b want 1", bus.instr_ready); end
  endtask

  task automatic test_stream();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.block_valid_out !== 1'b0) begin errors++; $display("FAIL stream_early_valid k=%0d got %0b want 0", k, bus.block_valid_out); end
      bus.instr_in = 32'h100 + 32'(k);
      bus.instr_valid = 1'b1;
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    exp_data = {32'h103, 32'h102, 32'h101, 32'h100};
    checks++; if (bus.block_valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid0 got %0b want 1", bus.block_valid_out); end
    checks++; if (bus.block_id_out !== 8'd0) begin errors++; $display("FAIL stream_id0 got %0d want 0", bus.block_id_out); end
    checks++; if (bus.block_len_out !== 3'd4) begin errors++; $display("FAIL stream_len0 got %0d want 4", bus.block_len_out); end
    checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL stream_data0 got %0h want %0h", bus.block_data_out, exp_data); end
    bus.block_accept = 1'b1;
    send_words(32'h104, 4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stream_send timeout got %0b want 1", ok); end
    exp_data = {32'h107, 32'h106, 32'h105, 32'h104};
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL stream_count1 got %0d want 1", bus.fifo_count); end
    checks++; if (bus.block_id_out !== 8'd1) begin errors++; $display("FAIL stream_id1 got %0d want 1", bus.block_id_out); end
    checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL stream_data1 got %0h want %0h", bus.block_data_out, exp_data); end
    @(negedge clk);
    bus.block_accept = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL stream_drained got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_flush();
    bit ok;
    send_words(32'hA0, 2, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_send timeout got %0b want 1", ok); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    exp_data = {32'h13, 32'h13, 32'hA1, 32'hA0};
    checks++; if (bus.block_valid_out !== 1'b1) begin errors++; $display("FAIL flush_valid got %0b want 1", bus.block_valid_out); end
    checks++; if (bus.block_id_out !== 8'd2) begin errors++; $display("FAIL flush_id got %0d want 2", bus.block_id_out); end
    checks++; if (bus.block_len_out !== 3'd2) begin errors++; $display("FAIL flush_len got %0d want 2", bus.block_len_out); end
    checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL flush_data got %0h want %0h", bus.block_data_out, exp_data); end
    bus.block_accept = 1'b1;
    @(negedge clk);
    bus.block_accept = 1'b0;
    // flush with nothing collected must not create a block
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL flush_empty_count got %0d want 0", bus.fifo_count); end
    // flush together with a transfer: that word is the only one in the block
    bus.instr_in = 32'hB0; bus.instr_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0; bus.flush = 1'b0;
    exp_data = {32'h13, 32'h13, 32'h13, 32'hB0};
    checks++; if (bus.block_id_out !== 8'd3) begin errors++; $display("FAIL flush_xfer_id got %0d want 3", bus.block_id_out); end
    checks++; if (bus.block_len_out !== 3'd1) begin errors++; $display("FAIL flush_xfer_len got %0d want 1", bus.block_len_out); end
    checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL flush_xfer_data got %0h want %0h", bus.block_data_out, exp_data); end
    bus.block_accept = 1'b1;
    @(negedge clk);
    bus.block_accept = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL flush_xfer_drain got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    send_words(32'h200, 19, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_send timeout got %0b want 1", ok); end
    bus.instr_in = 32'h213; bus.instr_valid = 1'b1;
    #1;
    exp_data = {32'h203, 32'h202, 32'h201, 32'h200};
    checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", bus.instr_ready); end
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", bus.fifo_count); end
    checks++; if (bus.block_id_out !== 8'd0) begin errors++; $display("FAIL full_head_id got %0d want 0", bus.block_id_out); end
    checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL full_head_data got %0h want %0h", bus.block_data_out, exp_data); end
    bus.block_accept = 1'b1;
    @(negedge clk);
    bus.block_accept = 1'b0;
    #1;
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", bus.fifo_count); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %0b want 1", bus.instr_ready); end
    checks++; if (bus.block_id_out !== 8'd1) begin errors++; $display("FAIL full_pop_id got %0d want 1", bus.block_id_out); end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_refill_count got %0d want 4", bus.fifo_count); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL full_refill_ready got %0b want 1", bus.instr_ready); end
  endtask

  task automatic test_flush_wait();
    bus.instr_in = 32'hC0; bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL fw_ready got %0b want 0", bus.instr_ready); end
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fw_count got %0d want 4", bus.fifo_count); end
    // a repeated flush while waiting must be ignored
    bus.block_accept = 1'b1;
    @(negedge clk);
    bus.block_accept = 1'b0; bus.flush = 1'b0;
    #1;
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL fw_pop_count got %0d want 3", bus.fifo_count); end
    checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL fw_pop_ready got %0b want 0", bus.instr_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fw_push_count got %0d want 4", bus.fifo_count); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL fw_push_ready got %0b want 1", bus.instr_ready); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (bus.block_id_out !== 8'(2 + j)) begin errors++; $display("FAIL fw_drain_id j=%0d got %0d want %0d", j, bus.block_id_out, 2 + j); end
      if (j == 2) begin
        exp_data = {32'h213, 32'h212, 32'h211, 32'h210};
        checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL fw_id4_data got %0h want %0h", bus.block_data_out, exp_data); end
      end
      if (j == 3) begin
        exp_data = {32'h13, 32'h13, 32'h13, 32'hC0};
        checks++; if (bus.block_len_out !== 3'd1) begin errors++; $display("FAIL fw_partial_len got %0d want 1", bus.block_len_out); end
        checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL fw_partial_data got %0h want %0h", bus.block_data_out, exp_data); end
      end
      bus.block_accept = 1'b1;
      @(negedge clk);
    end
    bus.block_accept = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL fw_drained got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_id_wrap();
    int sent = 0;
    int popped = 0;
    logic [7:0] exp_id = 8'd0;
    do_reset();
    bus.block_accept = 1'b1;
    for (int cyc = 0; cyc < 1100 && popped < 260; cyc++) begin
      @(negedge clk);
      if (bus.block_valid_out) begin
        checks++; if (bus.block_id_out !== exp_id) begin errors++; $display("FAIL wrap_id blk=%0d got %0d want %0d", popped, bus.block_id_out, exp_id); end
        exp_id = exp_id + 8'd1;
        popped++;
      end
      if (sent < 1040) begin
        bus.instr_in = 32'(sent); bus.instr_valid = 1'b1;
        #1;
        if (bus.instr_ready) sent++;
      end else begin
        bus.instr_valid = 1'b0;
      end
    end
    bus.block_accept = 1'b0;
    bus.instr_valid = 1'b0;
    checks++; if (popped !== 260) begin errors++; $display("FAIL wrap_blocks got %0d want 260", popped); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    send_words(32'h300, 14, ok);
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", bus.fifo_count); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.block_valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", bus.block_valid_out); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", bus.fifo_count); end
    rst = 1'b0;
    send_words(32'h400, 4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_send timeout got %0b want 1", ok); end
    exp_data = {32'h403, 32'h402, 32'h401, 32'h400};
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL mid_new_count got %0d want 1", bus.fifo_count); end
    checks++; if (bus.block_id_out !== 8'd0) begin errors++; $display("FAIL mid_new_id got %0d want 0", bus.block_id_out); end
    checks++; if (bus.block_data_out !== exp_data) begin errors++; $display("FAIL mid_new_data got %0h want %0h", bus.block_data_out, exp_data); end
  endtask

  initial begin
    bus.instr_in = '0; bus.instr_valid = 1'b0; bus.flush = 1'b0; bus.block_accept = 1'b0;
    test_reset();
    test_stream();
    test_flush();
    test_full();
    test_flush_wait();
    test_id_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
